// File: rtl/sobel_filter_pipe_if.sv
// Pixel stream bundle for sobel_filter_pipe: gray pixels in, filtered pixels out.
interface sobel_filter_pipe_if #(
  parameter int PIX_W = 12,
  parameter int OUT_W = 12
);
  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] in_pixel;
  logic [1:0]       mode;
  logic             out_valid;
  logic [OUT_W-1:0] out_pixel;
  logic             out_border;

  modport master (
    output in_valid, in_sof, in_pixel, mode,
    input  out_valid, out_pixel, out_border
  );

  modport slave (
    input  in_valid, in_sof, in_pixel, mode,
    output out_valid, out_pixel, out_border
  );
endinterface

// File: rtl/sobel_filter_pipe.sv
// Streaming 3x3 Sobel filter, raster-order gray pixels, fixed two-cycle latency.
// Two line buffers supply the older rows of the newest window column; the two
// older columns live in window registers. Output is |Gx|, |Gy| or |Gx|+|Gy|,
// saturated to OUT_W bits, with border pixels (row<2 or col<2) forced to 0.
// Optional build macro THRESHOLD_EN adds a thresh port and binarises the output.
module sobel_filter_pipe #(
  parameter int PIX_W  = 12,
  parameter int OUT_W  = 12,
  parameter int LINE_W = 640
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef THRESHOLD_EN
  input  logic [OUT_W-1:0] thresh,
`endif
  sobel_filter_pipe_if.slave bus
);

  localparam int GW    = PIX_W + 4;
  localparam int CW    = ((GW > OUT_W) ? GW : OUT_W) + 1;
  localparam int COL_W = $clog2(LINE_W);
  localparam logic [CW-1:0] SAT_MAX = {{(CW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [PIX_W-1:0] lb1 [LINE_W];
  logic [PIX_W-1:0] lb2 [LINE_W];
  logic [PIX_W-1:0] win [3][2];

  logic [COL_W-1:0] col_q, col_cur;
  logic [1:0]       row_q, row_cur;
  logic [1:0]       mode_q, mode_cur;
  logic             first, col_wrap, border_cur;
  logic [PIX_W-1:0] top_px, mid_px;
  logic signed [GW-1:0] gx, gy;

  logic                 s1_valid, s1_border;
  logic [1:0]           s1_mode;
  logic signed [GW-1:0] s1_gx, s1_gy;

  logic [GW-1:0]    abs_x, abs_y, res;
  logic [CW-1:0]    res_wide;
  logic [OUT_W-1:0] sat, result;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  // Position and mode that apply to the pixel presented this cycle; SOF restarts the frame.
  always_comb begin
    first      = bus.in_valid & bus.in_sof;
    col_cur    = first ? '0 : col_q;
    row_cur    = first ? '0 : row_q;
    mode_cur   = first ? bus.mode : mode_q;
    col_wrap   = (col_cur == COL_W'(LINE_W - 1));
    border_cur = (row_cur < 2'd2) || (col_cur < COL_W'(2));
    top_px     = lb2[col_cur];
    mid_px     = lb1[col_cur];
  end

  // Gradients over the two registered columns plus the incoming column.
  always_comb begin
    gx = (ext(top_px) + (ext(mid_px) <<< 1) + ext(bus.in_pixel))
       - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
    gy = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(bus.in_pixel))
       - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(top_px));
  end

  // Column/row tracking and frame mode; advances only on accepted pixels, row sticks at 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= 2'd2;
    end else if (bus.in_valid) begin
      col_q  <= col_wrap ? '0 : col_cur + 1'b1;
      row_q  <= (col_wrap && row_cur != 2'd2) ? row_cur + 1'b1 : row_cur;
      mode_q <= mode_cur;
    end
  end

  // Line buffers and window shift; stale contents are hidden by border masking.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      lb2[col_cur] <= mid_px;
      lb1[col_cur] <= bus.in_pixel;
      for (int r = 0; r < 3; r++) win[r][0] <= win[r][1];
      win[0][1] <= top_px;
      win[1][1] <= mid_px;
      win[2][1] <= bus.in_pixel;
    end
  end

  // Stage 1: capture gradients, border flag and the mode that goes with this pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_border <= 1'b0;
      s1_mode   <= 2'd2;
      s1_gx     <= '0;
      s1_gy     <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_border <= border_cur;
        s1_mode   <= mode_cur;
        s1_gx     <= gx;
        s1_gy     <= gy;
      end
    end
  end

  // Magnitude select and saturation; the sum of both magnitudes always fits in GW bits.
  always_comb begin
    abs_x = s1_gx[GW-1] ? $unsigned(-s1_gx) : $unsigned(s1_gx);
    abs_y = s1_gy[GW-1] ? $unsigned(-s1_gy) : $unsigned(s1_gy);
    case (s1_mode)
      2'd0:    res = abs_x;
      2'd1:    res = abs_y;
      default: res = abs_x + abs_y;
    endcase
    res_wide = CW'(res);
    sat      = (res_wide > SAT_MAX) ? {OUT_W{1'b1}} : res_wide[OUT_W-1:0];
`ifdef THRESHOLD_EN
    result   = (sat >= thresh) ? {OUT_W{1'b1}} : '0;
`else
    result   = sat;
`endif
  end

  // Stage 2: registered outputs, held while no pixel completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_pixel  <= '0;
      bus.out_border <= 1'b0;
    end else begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_border <= s1_border;
        bus.out_pixel  <= s1_border ? '0 : result;
      end
    end
  end

endmodule
